// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine driver.
package gcd_pkg;

  localparam int GCD_DATA_W         = 32;
  localparam int GCD_TIMEOUT_CYCLES = 65536;
  localparam int GCD_STAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } gcd_drv_state_e;

  typedef struct packed {
    logic [GCD_DATA_W-1:0] data;
    logic                  err;
  } gcd_result_t;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Watchdog counter for one engine operation; saturates at the terminal count.
module gcd_timeout_ctr #(
  parameter int LIMIT = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_r;

  // cycle counter, cleared at issue and advanced while waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == LAST);

endmodule

// File: rtl/gcd_driver.sv
// Initiator for the subtractive GCD engine: operand stream in, one start
// pulse per pair, timeout-guarded wait, result stream out plus statistics.
module gcd_driver
  import gcd_pkg::*;
#(
  parameter int DATA_W         = GCD_DATA_W,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES,
  parameter int STAT_W         = GCD_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  output logic              eng_start,
  input  logic [DATA_W-1:0] eng_result,
  input  logic              eng_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic [STAT_W-1:0] ops_done,
  output logic [STAT_W-1:0] ops_timeout
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } result_t;

  gcd_drv_state_e    state_r;
  gcd_drv_state_e    state_nxt_s;
  result_t           res_r;
  result_t           res_nxt_s;
  logic [DATA_W-1:0] eng_a_nxt_s;
  logic [DATA_W-1:0] eng_b_nxt_s;
  logic [STAT_W-1:0] ops_done_nxt_s;
  logic [STAT_W-1:0] ops_timeout_nxt_s;
  logic              timer_clr_s;
  logic              timer_en_s;
  logic              timer_tc_s;

  gcd_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clr_s),
    .enable(timer_en_s),
    .tc    (timer_tc_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state, operand latch, result capture and statistics update
  always_comb begin
    state_nxt_s       = state_r;
    res_nxt_s         = res_r;
    eng_a_nxt_s       = eng_a;
    eng_b_nxt_s       = eng_b;
    ops_done_nxt_s    = ops_done;
    ops_timeout_nxt_s = ops_timeout;
    timer_clr_s       = 1'b0;
    timer_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_valid) begin
          eng_a_nxt_s = op_a;
          eng_b_nxt_s = op_b;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        // eng_done is deliberately not looked at here: it still reflects the previous load
        timer_clr_s = 1'b1;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          res_nxt_s.data = eng_result;
          res_nxt_s.err  = 1'b0;
          ops_done_nxt_s = ops_done + STAT_W'(1'b1);
          state_nxt_s    = HOLD;
        end else if (timer_tc_s) begin
          res_nxt_s.data    = {DATA_W{1'b0}};
          res_nxt_s.err     = 1'b1;
          ops_timeout_nxt_s = ops_timeout + STAT_W'(1'b1);
          state_nxt_s       = HOLD;
        end else begin
          timer_en_s  = 1'b1;
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // registered outputs, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      op_ready    <= 1'b1;
      eng_start   <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      eng_a       <= {DATA_W{1'b0}};
      eng_b       <= {DATA_W{1'b0}};
      res_r       <= {(DATA_W + 1){1'b0}};
      ops_done    <= {STAT_W{1'b0}};
      ops_timeout <= {STAT_W{1'b0}};
    end else begin
      op_ready    <= (state_nxt_s == IDLE);
      eng_start   <= (state_nxt_s == ISSUE);
      res_valid   <= (state_nxt_s == HOLD);
      busy        <= (state_nxt_s != IDLE);
      eng_a       <= eng_a_nxt_s;
      eng_b       <= eng_b_nxt_s;
      res_r       <= res_nxt_s;
      ops_done    <= ops_done_nxt_s;
      ops_timeout <= ops_timeout_nxt_s;
    end
  end

  assign res_data = res_r.data;
  assign res_err  = res_r.err;

endmodule
